// File: rtl/wino_pkg.sv
// rtl/wino_pkg.sv - shared weight-bank constants, load FSM states and tile lane helper
package wino_pkg;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;
  localparam int ELEM_W = 12;
  localparam int TILE   = 6;
  localparam int NELEM  = TILE * TILE;
  localparam int WORD_W = 512;
  localparam int PACK_W = NELEM * ELEM_W;

  typedef enum logic [1:0] {
    LD_IDLE,
    LD_FILL,
    LD_WRITE,
    LD_DONE
  } load_state_t;

  // Lane number of a tile element; elements arrive row-major.
  function automatic logic [5:0] pack_index(input logic [2:0] row, input logic [2:0] col);
    return 6'(row) * 6'(TILE) + 6'(col);
  endfunction

endpackage

// File: rtl/weight_tile_packer.sv
// rtl/weight_tile_packer.sv - assembles one 6x6 tile of weights into a packed word
module weight_tile_packer #(
  parameter int ELEM_W = 12,
  parameter int TILE   = 6
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          shift_en,
  input  logic [ELEM_W-1:0]             elem,
  output logic [TILE*TILE*ELEM_W-1:0]   pack,
  output logic                          full
);
  import wino_pkg::pack_index;

  localparam int PACK_W = TILE * TILE * ELEM_W;
  localparam int LSB_W  = $clog2(PACK_W);
  localparam logic [2:0] EDGE_LAST = 3'(TILE - 1);

  logic [2:0]       row_q;
  logic [2:0]       col_q;
  logic [LSB_W-1:0] lane_lsb;

  assign lane_lsb = LSB_W'(pack_index(row_q, col_q)) * LSB_W'(ELEM_W);

  // High while the element completing the tile is being accepted.
  assign full = shift_en && (row_q == EDGE_LAST) && (col_q == EDGE_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_q <= '0;
      col_q <= '0;
      pack  <= '0;
    end else if (clear) begin
      row_q <= '0;
      col_q <= '0;
      pack  <= '0;
    end else if (shift_en) begin
      pack[lane_lsb +: ELEM_W] <= elem;
      if (col_q == EDGE_LAST) begin
        col_q <= '0;
        row_q <= (row_q == EDGE_LAST) ? 3'd0 : row_q + 3'd1;
      end else begin
        col_q <= col_q + 3'd1;
      end
    end
  end

endmodule

// File: rtl/weight_bank.sv
// rtl/weight_bank.sv - dual-read-port weight store filled by a tile-packing load engine
module weight_bank #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int ELEM_W = 12,
  parameter int TILE   = 6,
  parameter int WORD_W = 512
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start_i,
  input  logic [ADDR_W-1:0] load_base_i,
  input  logic [ADDR_W-1:0] load_count_i,
  input  logic [ELEM_W-1:0] load_elem_i,
  input  logic              load_elem_valid_i,
  output logic              load_elem_ready_o,
  output logic              load_busy_o,
  output logic              load_done_o,
  input  logic [ADDR_W-1:0] weight_addr_i_1,
  input  logic [ADDR_W-1:0] weight_addr_i_2,
  input  logic              weight_package_1_valid_i,
  input  logic              weight_package_2_valid_i,
  output logic [WORD_W-1:0] weight_data_o_1,
  output logic [WORD_W-1:0] weight_data_o_2,
  output logic [ADDR_W-1:0] weight_addr_o_1,
  output logic [ADDR_W-1:0] weight_addr_o_2,
  output logic              weight_valid_o_1,
  output logic              weight_valid_o_2
);
  import wino_pkg::*;

  localparam int FILL_W = TILE * TILE * ELEM_W;

  load_state_t       state_q;
  load_state_t       state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] remain_q;
  logic [FILL_W-1:0] pack;
  logic              tile_full;
  logic              accept;
  logic              start_take;

  // Only the used lanes are stored; the upper word bits are zero-filled on read.
  logic [FILL_W-1:0] mem [DEPTH];

  assign start_take = (state_q == LD_IDLE) && load_start_i;
  assign accept     = load_elem_valid_i && load_elem_ready_o;

  weight_tile_packer #(
    .ELEM_W (ELEM_W),
    .TILE   (TILE)
  ) u_packer (
    .clk      (clk),
    .reset    (reset),
    .clear    (start_take),
    .shift_en (accept),
    .elem     (load_elem_i),
    .pack     (pack),
    .full     (tile_full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= LD_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LD_IDLE: begin
        if (load_start_i) begin
          state_d = (load_count_i == '0) ? LD_DONE : LD_FILL;
        end
      end
      LD_FILL: begin
        if (tile_full) begin
          state_d = LD_WRITE;
        end
      end
      LD_WRITE: begin
        state_d = (remain_q == ADDR_W'(1)) ? LD_DONE : LD_FILL;
      end
      LD_DONE: begin
        state_d = LD_IDLE;
      end
      default: begin
        state_d = LD_IDLE;
      end
    endcase
  end

  assign load_elem_ready_o = (state_q == LD_FILL);
  assign load_busy_o       = (state_q != LD_IDLE);
  assign load_done_o       = (state_q == LD_DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q   <= '0;
      remain_q <= '0;
    end else if (start_take) begin
      addr_q   <= load_base_i;
      remain_q <= load_count_i;
    end else if (state_q == LD_WRITE) begin
      addr_q   <= (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);
      remain_q <= remain_q - ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == LD_WRITE) begin
      mem[addr_q] <= pack;
    end
  end

  // Reads sample the array before this edge's write lands: read-before-write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      weight_valid_o_1 <= 1'b0;
      weight_valid_o_2 <= 1'b0;
      weight_data_o_1  <= '0;
      weight_data_o_2  <= '0;
      weight_addr_o_1  <= '0;
      weight_addr_o_2  <= '0;
    end else begin
      weight_valid_o_1 <= weight_package_1_valid_i;
      weight_valid_o_2 <= weight_package_2_valid_i;
      if (weight_package_1_valid_i) begin
        weight_data_o_1 <= WORD_W'(mem[weight_addr_i_1]);
        weight_addr_o_1 <= weight_addr_i_1;
      end
      if (weight_package_2_valid_i) begin
        weight_data_o_2 <= WORD_W'(mem[weight_addr_i_2]);
        weight_addr_o_2 <= weight_addr_i_2;
      end
    end
  end

endmodule

// File: doc/weight_bank.md
# weight_bank

Dual-read-port on-chip weight store that answers the weight controller's package requests and is filled from an off-chip element stream. A load engine packs 36 signed 12-bit Winograd-domain weights, one 6x6 tile, into each 512-bit word and writes the words to consecutive addresses. Two independent read ports return the word, the echoed address and a valid flag exactly one cycle after each request. The block sits between the off-chip loader and the weight controller, on the memory side of the weight request/response interface.

## Interface
Parameters:
- ADDR_W, 8, word address width
- DEPTH, 256, number of words (2^ADDR_W)
- ELEM_W, 12, width of one weight element
- TILE, 6, tile edge; TILE*TILE = 36 elements per word
- WORD_W, 512, word width; bits above 36*ELEM_W (431) are always zero

Ports:
- clk  in  1  the single clock; all state updates on its rising edge
- reset  in  1  asynchronous reset, **active-low**
- load_start_i  in  1  one-cycle pulse that starts a load; ignored while load_busy_o=1
- load_base_i  in  ADDR_W  first word address, sampled with load_start_i
- load_count_i  in  ADDR_W  number of words to load, sampled with load_start_i
- load_elem_i  in  ELEM_W  signed weight element
- load_elem_valid_i  in  1  load_elem_i is valid
- load_elem_ready_o  out  1  the element is accepted when valid and ready are both 1
- load_busy_o  out  1  a load is in progress
- load_done_o  out  1  one-cycle pulse when a load completes
- weight_addr_i_1 / weight_addr_i_2  in  ADDR_W  read address for port 1 / port 2
- weight_package_1_valid_i / weight_package_2_valid_i  in  1  read request for the matching port
- weight_data_o_1 / weight_data_o_2  out  WORD_W  returned word
- weight_addr_o_1 / weight_addr_o_2  out  ADDR_W  echo of the address the word came from
- weight_valid_o_1 / weight_valid_o_2  out  1  the returned word is valid

## Operation
- Word packing: element k, where k = row*6 + col and k = 0..35 in arrival order, occupies bits [k*12 +: 12]. Bits 511:432 are written as 0.
- Load FSM states:
  - IDLE: ready=0, busy=0. A load_start_i pulse latches base and count, clears the element counter, then goes to FILL, or to DONE if count=0.
  - FILL: ready=1, busy=1. Each accepted element shifts into the pack register and increments the element counter. When the 36th element is accepted, the next state is WRITE.
  - WRITE: ready=0, busy=1. Writes the pack register to the current address, increments the address modulo DEPTH (255 wraps to 0) and decrements the remaining count. Goes to FILL if the remaining count is nonzero, otherwise to DONE.
  - DONE: load_done_o=1 for exactly one cycle, busy=1, then IDLE.
- A gap in load_elem_valid_i stalls FILL indefinitely. There is no timeout.
- Read ports are independent and are served every cycle in every FSM state. Both ports may read the same address in the same cycle.
- Read and write to the same address in the same cycle returns the old data (read-before-write).
- The memory array has no reset. Contents survive reset.

## Timing
- Read latency is exactly 1 cycle: a request in cycle N produces valid_o=1, addr_o = addr_i and data_o = mem[addr_i] in cycle N+1. A cycle with no request gives valid_o=0 in the next cycle, with data and addr holding their last values.
- Back-to-back requests on each port give full throughput, one word per cycle per port.
- Load throughput is 37 cycles per word with continuous valid (36 FILL cycles + 1 WRITE). A word written in WRITE cycle W is readable by a request in cycle W+1.
- With count=0: start in cycle N, DONE in N+1, no writes.
- Reset values of all outputs are 0: data, addr, valid, ready, busy, done. The FSM returns to IDLE and all counters and the pack register clear. A reset during a load abandons it, and a partial word is never written.

## Structure
- Shared package `wino_pkg`: ELEM_W, TILE, WORD_W, ADDR_W, the load-FSM state enum, and a `pack_index(row, col)` function that returns row*TILE+col.
- Sub-module `weight_tile_packer`: the shift/pack register and the 0..35 element counter, with a `full` output.
- The top level holds the FSM, the address and count registers, the memory array with two read ports and one write port, and the output registers.

## Test plan
- Load base=4, count=1, elements k+1 for k=0..35 → load_done_o pulses once. A port-1 read of address 4 returns lane k = k+1, bits 511:432 = 0, weight_addr_o_1=4, and valid exactly 1 cycle after the request.
- Both ports read address 4 in the same cycle, then back-to-back reads of addresses 4 and 5 → identical data on both ports, one response per cycle, correct address echoes.
- Load with valid dropped for 3 cycles after elements 10 and 35 → the stored word is unchanged versus continuous valid, and the total load time is 37+6 cycles.
- Load base=255, count=2 → words land at addresses 255 and 0; a start pulse issued mid-load is ignored.
- In the WRITE cycle of a reload of address 4, port 2 reads address 4 → it returns the old word; a read in the next cycle returns the new word.
- Assert reset after 20 elements → all outputs are 0 and the FSM is IDLE. Address 4 keeps its prior contents. A new load after release completes normally. A load with count=0 gives load_done_o at N+1 and no writes.
